// File: rtl/sqrt_checker.sv
// Checks a square-root core's answer: squares the reported root with a 4-step
// shift-add multiplier, then tests root^2 <= x < (root+1)^2 and keeps saturating pass/fail tallies.
module sqrt_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       x,
  input  logic [3:0]       root,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       err,
  output logic [7:0]       root_sq,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ADJ,
    CMP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic [6:0] x_lat;
  logic [3:0] root_lat;
  logic [7:0] acc;
  logic [1:0] bit_cnt;
  logic [8:0] hi;

  logic [7:0] partial;
  logic       too_large;
  logic       too_small;

  // Partial product for the current multiplier bit; acc ends up holding lo = root^2.
  always_comb begin
    partial = 8'd0;
    if (root_lat[bit_cnt])
      partial = {4'b0000, root_lat} << bit_cnt;
  end

  // hi is 9 bits wide so root=15 yields 256 rather than wrapping to 0.
  always_comb begin
    too_large = acc > {1'b0, x_lat};
    too_small = {2'b00, x_lat} >= hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err      <= 2'b00;
      root_sq  <= 8'd0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      x_lat    <= 7'd0;
      root_lat <= 4'd0;
      acc      <= 8'd0;
      bit_cnt  <= 2'd0;
      hi       <= 9'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_lat    <= x;
            root_lat <= root;
            acc      <= 8'd0;
            bit_cnt  <= 2'd0;
            busy     <= 1'b1;
            state    <= MUL;
          end
        end
        MUL: begin
          acc     <= acc + partial;
          bit_cnt <= bit_cnt + 2'd1;
          if (bit_cnt == 2'd3)
            state <= ADJ;
        end
        ADJ: begin
          hi    <= {1'b0, acc} + {4'b0000, root_lat, 1'b0} + 9'd1;
          state <= CMP;
        end
        CMP: begin
          root_sq <= acc;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
          // Root too large outranks root too small.
          if (too_large) begin
            pass <= 1'b0;
            err  <= 2'b01;
          end else if (too_small) begin
            pass <= 1'b0;
            err  <= 2'b10;
          end else begin
            pass <= 1'b1;
            err  <= 2'b00;
          end
          if (too_large || too_small) begin
            if (fail_cnt != CNT_MAX)
              fail_cnt <= fail_cnt + CNT_ONE;
          end else begin
            if (pass_cnt != CNT_MAX)
              pass_cnt <= pass_cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
